shift_chain_driver: RTL

- Downstream consumer of the SPI slave's 400-bit register bank.
- Snapshots the bank and shifts it serially into an external 74HC595-style shift-register chain, then pulses the storage latch so all chain outputs update at once.
- Starts a frame on a bank change, an explicit request, or an optional periodic refresh.
- Keeps the chain's output enable deasserted until the first complete frame has been latched after reset.

---
 rtl/shift_chain_driver_if.sv | 24 ++
 rtl/shift_chain_driver.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/shift_chain_driver_if.sv
// Bank input, frame request and 74HC595-style chain outputs of shift_chain_driver.
// master = the driver, slave = the environment (bank source and chain).
interface shift_chain_driver_if #(
  parameter int NBITS = 400
);
  logic [NBITS-1:0] reg_bits;
  logic             update_req;
  logic             sr_data;
  logic             sr_clk;
  logic             sr_latch;
  logic             sr_oe_n;
  logic             busy;
  logic             done;

  modport master (
    input  reg_bits, update_req,
    output sr_data, sr_clk, sr_latch, sr_oe_n, busy, done
  );

  modport slave (
    output reg_bits, update_req,
    input  sr_data, sr_clk, sr_latch, sr_oe_n, busy, done
  );
endinterface

// File: rtl/shift_chain_driver.sv
// Snapshots the register bank and shifts it MSB-first into a 595-style chain, then latches.
// States: IDLE wait | LOAD snapshot | SHIFT_LO/HI clock one bit | LATCH_SU setup | LATCH pulse | DONE.
module shift_chain_driver #(
  parameter int NBITS          = 400,
  parameter int CLK_DIV        = 4,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_chain_driver_if.master bus
);
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int PW = $clog2(CLK_DIV) + 1;
  localparam int RW = $clog2(REFRESH_CYCLES) + 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(NBITS - 1);
  localparam logic [PW-1:0] PH_LOAD = PW'(CLK_DIV - 1);
  localparam logic [RW-1:0] REF_HIT = RW'((REFRESH_CYCLES >= 2) ? REFRESH_CYCLES - 2 : 0);
  localparam logic [RW-1:0] REF_SAT = RW'((REFRESH_CYCLES >= 1) ? REFRESH_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH_SU, LATCH, DONE
  } state_t;

  state_t           state, state_d;
  logic [PW-1:0]    phase;
  logic [IW-1:0]    index, index_d;
  logic [NBITS-1:0] snapshot, snapshot_d;
  logic             pending;
  logic [RW-1:0]    ref_cnt;
  logic             phase_tc, bank_changed, refresh_hit, trigger;
  logic sr_data_d, sr_clk_d, sr_latch_d, sr_oe_n_d, busy_d, done_d;
  logic sr_data_q, sr_clk_q, sr_latch_q, sr_oe_n_q, busy_q, done_q;

  assign phase_tc     = (phase == '0);
  assign bank_changed = (bus.reg_bits != snapshot);
  // Fires one count early so the LOAD lands exactly REFRESH_CYCLES idle cycles after DONE.
  assign refresh_hit  = (REFRESH_CYCLES > 0) && (state == IDLE) && !pending &&
                        (ref_cnt >= REF_HIT);
  assign trigger      = bus.update_req || bank_changed || refresh_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    index_d    = index;
    snapshot_d = snapshot;
    case (state)
      IDLE:     if (pending) state_d = LOAD;
      LOAD: begin
        snapshot_d = bus.reg_bits;
        index_d    = IDX_MSB;
        state_d    = SHIFT_LO;
      end
      SHIFT_LO: if (phase_tc) state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (phase_tc) begin
          if (index == '0) begin
            state_d = LATCH_SU;
          end else begin
            index_d = index - 1'b1;
            state_d = SHIFT_LO;
          end
        end
      end
      LATCH_SU: if (phase_tc) state_d = LATCH;
      LATCH:    if (phase_tc) state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      index    <= '0;
      snapshot <= '0;
      pending  <= 1'b1;
      ref_cnt  <= '0;
    end else begin
      phase    <= (state_d != state) ? PH_LOAD : (phase_tc ? phase : phase - 1'b1);
      index    <= index_d;
      snapshot <= snapshot_d;
      // The LOAD cycle's compare sees the old snapshot; only a request there re-arms.
      if (state == LOAD)  pending <= bus.update_req;
      else if (trigger)   pending <= 1'b1;
      if (state != IDLE)     ref_cnt <= '0;
      else if (refresh_hit)  ref_cnt <= REF_SAT;
      else if (trigger)      ref_cnt <= '0;
      else if (!pending)     ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    sr_data_d  = 1'b0;
    sr_clk_d   = 1'b0;
    sr_latch_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    sr_oe_n_d  = sr_oe_n_q && (state_d != DONE);
    case (state_d)
      LOAD:     busy_d = 1'b1;
      SHIFT_LO: begin
        busy_d    = 1'b1;
        sr_data_d = snapshot_d[index_d];
      end
      SHIFT_HI: begin
        busy_d    = 1'b1;
        sr_clk_d  = 1'b1;
        sr_data_d = snapshot_d[index_d];
      end
      LATCH_SU: busy_d = 1'b1;
      LATCH: begin
        busy_d     = 1'b1;
        sr_latch_d = 1'b1;
      end
      DONE:     done_d = 1'b1;
      default:  busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_data_q  <= 1'b0;
      sr_clk_q   <= 1'b0;
      sr_latch_q <= 1'b0;
      sr_oe_n_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sr_data_q  <= sr_data_d;
      sr_clk_q   <= sr_clk_d;
      sr_latch_q <= sr_latch_d;
      sr_oe_n_q  <= sr_oe_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.sr_data  = sr_data_q;
  assign bus.sr_clk   = sr_clk_q;
  assign bus.sr_latch = sr_latch_q;
  assign bus.sr_oe_n  = sr_oe_n_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule
